// File: rtl/seq_addsub.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock, LSB chunk first, WIDTH/CHUNK cycles per op.
// Optional macro SEQ_ADDSUB_ACC_EN: acc=1 on accept uses the current s result as operand A.
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    input  logic             acc,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_src;
    logic [CHUNK-1:0] op_a, op_b;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_ext;
    logic             msb_cin;

`ifdef SEQ_ADDSUB_ACC_EN
    assign a_src = acc ? s_q : a;
`else
    logic unused_acc;
    assign unused_acc = acc;
    assign a_src      = a;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Operand registers shift right, so the live chunk is always the low CHUNK bits.
        op_a      = a_q[CHUNK-1:0];
        op_b      = b_q[CHUNK-1:0];
        chunk_sum = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from the sum bit.
        msb_cin   = chunk_sum[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
        sum_ext   = '0;
        sum_ext[CHUNK-1:0] = chunk_sum[CHUNK-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    idx_d   = '0;
                    a_d     = a_src;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    res_d   = '0;
                end
            end
            CALC: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_sum[CHUNK];
                res_d   = (res_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    s_d     = res_d;
                    c_out_d = chunk_sum[CHUNK];
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub (WIDTH=8, CHUNK=4): driver pushes hand-computed results, monitor checks on done.
module tb_seq_addsub;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, c_in, sub, acc;
    logic [7:0] a, b;
    logic       ready, done, c_out, ovf;
    logic [7:0] s;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic done_prev = 1'b0;

    seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in),
        .sub(sub), .acc(acc), .ready(ready), .done(done), .s(s),
        .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Waits for ready at a negedge, presents one op for one edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic isub, input logic iacc, input bit do_push,
                         input logic [7:0] es, input logic ec, input logic eo);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", ready, 1);
        a = ia; b = ib; c_in = ic; sub = isub; acc = iacc; start = 1'b1;
        if (do_push) begin
            e.s = es; e.c = ec; e.o = eo;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = 8'hEE; b = 8'hDD; c_in = 1'b1; sub = 1'b1; acc = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_single", done_prev, 0);
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("s", s, e.s);
                chk("c_out", c_out, e.c);
                chk("ovf", ovf, e.o);
            end
        end
        done_prev = done;
    end

    // Back-to-back vectors with start held high; only the ones seen while ready are accepted.
    logic [7:0] bb_a [7] = '{8'h12, 8'hFF, 8'hAA, 8'h50, 8'h01, 8'h80, 8'hC0};
    logic [7:0] bb_b [7] = '{8'h34, 8'hFF, 8'h55, 8'h50, 8'h02, 8'h80, 8'hC0};
    logic [7:0] bb_s [7] = '{8'h46, 8'hFE, 8'hFF, 8'hA0, 8'h03, 8'h00, 8'h80};
    logic       bb_c [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       bb_o [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int   n_acc;
        exp_t e;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; acc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_s", s, 8'h00);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);

        // 0x0F + 0x01 with latency check
        issue(8'h0F, 8'h01, 0, 0, 0, 1, 8'h10, 0, 0);
        chk("lat_busy1", ready, 0);
        @(negedge clk);
        chk("lat_busy2", ready, 0);
        @(negedge clk);
        chk("lat_ready", ready, 1);
        chk("lat_done", done, 1);

        issue(8'h7F, 8'h01, 0, 0, 0, 1, 8'h80, 0, 1);
        issue(8'hFF, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0);
        issue(8'h00, 8'h01, 1, 1, 0, 1, 8'hFF, 0, 0);
        issue(8'h80, 8'h01, 0, 1, 0, 1, 8'h7F, 1, 1);
        drain();

        n_acc = 0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            a = bb_a[i]; b = bb_b[i]; c_in = 1'b0; sub = 1'b0; acc = 1'b0; start = 1'b1;
            if (ready) begin
                e.s = bb_s[i]; e.c = bb_c[i]; e.o = bb_o[i];
                sb.push_back(e);
                n_acc++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("bb_accepts", n_acc, 3);
        drain();

        // Abort with reset one cycle after accept: no done, outputs cleared.
        issue(8'h0F, 8'h01, 0, 0, 0, 0, 8'h00, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_s", s, 8'h00);
        chk("abort_c_out", c_out, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        repeat (3) @(negedge clk);
        issue(8'h23, 8'h45, 0, 0, 0, 1, 8'h68, 0, 0);
        drain();

        // Accumulate sequence
        issue(8'h05, 8'h00, 0, 0, 0, 1, 8'h05, 0, 0);
        issue(8'h05, 8'h03, 0, 0, 1, 1, 8'h08, 0, 0);
`ifdef SEQ_ADDSUB_ACC_EN
        issue(8'h05, 8'h03, 0, 0, 1, 1, 8'h0B, 0, 0);
`else
        issue(8'h05, 8'h03, 0, 0, 1, 1, 8'h08, 0, 0);
`endif
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
